vector_broadcast_unit: RTL and testbench
========================================

// Module: vector_broadcast_unit
// PURPOSE
//  Parametrised successor broadcast engine. Caches up to DEPTH operand elements (weights/data)
//  written from SRAM and streams them as LANES-wide beats to the PE array with a valid/ready
//  handshake. Supports cyclic wrap-around (WRAP) and per-beat scalar replication (SCALAR).
//  Runs a programmed number of beats, then pulses done.
// PARAMETERS
//  LANES   8    elements per beat, >=1
//  DATA_W  8    element width, bits
//  DEPTH   512  cache entries; power of 2
//  ADDR_W  $clog2(DEPTH)  cache index width
//  BEAT_W  32   beat counter width
// PORTS
//  clk            in   1               clock
//  rst            in   1               reset, synchronous, active-low
//  init           in   1               sync clear: cache_valid, base, FSM, outputs (cache data kept)
//  wr_valid       in   1               write LANES elements into cache
//  wr_addr        in   ADDR_W          first entry written; entry k -> (wr_addr+k) mod DEPTH
//  wr_data        in   LANES*DATA_W    element k at [k*DATA_W +: DATA_W]
//  start          in   1               launch run using cfg_* (sampled this cycle)
//  cfg_mode       in   2               0 WRAP, 1 SCALAR, 2/3 reserved = WRAP
//  cfg_num_elems  in   ADDR_W+1        period n; 0 treated as 1, >DEPTH clamped to DEPTH
//  cfg_num_beats  in   BEAT_W          beats to emit
//  out_valid      out  1               beat valid
//  out_ready      in   1               consumer accepts beat
//  out_data       out  LANES*DATA_W    lane j at [j*DATA_W +: DATA_W]
//  out_last       out  1               final beat of run (qualified by out_valid)
//  busy           out  1               FSM not IDLE
//  done           out  1               1-cycle pulse, run complete
// BEHAVIOUR
//  - Reset/init: out_valid, out_data, out_last, busy, done = 0; base=0; all cache_valid=0; FSM IDLE.
//  - FSM: IDLE -start-> RUN (if num_beats>0) else DONE; RUN -last beat accepted-> DONE; DONE -> IDLE (done=1 one cycle).
//  - start ignored unless IDLE; cfg_* latched on start, base=0, beat count=0.
//  - Lane indices: WRAP idx_j=(base+j) mod n; SCALAR idx_j=base for all j.
//    Next base: WRAP (base+LANES) mod n; SCALAR (base+1) mod n. No divider: incremental +1/wrap chain.
//  - Output register advances when !out_valid || out_ready (full-throughput, no bubbles).
//    Issue requires cache_valid of every addressed entry; else hold (out_valid low or held beat).
//  - Latency: start at cycle t, entries valid -> out_valid=1 at t+1. Held beat: out_data stable until accepted.
//  - out_last=1 on beat number num_beats-1; its acceptance moves RUN->DONE.
//  - Writes permitted in any state; write and issue same cycle: issue sees pre-write state (see CONFIGURATION).
//  - init mid-run aborts: IDLE next cycle, no done pulse, pending beat dropped. init has priority over wr_valid/start.
//  - Overlapping write addresses wrap at DEPTH; last-written value wins.
// CONFIGURATION
//  BCAST_FWD_EN defined: entries being written this cycle count as valid for issue; their wr_data
//    forwarded to out_data same cycle (write->beat stall-free).
//  Not defined: no forwarding; beat depending on an in-flight write waits one cycle.
// STRUCTURE
//  Package npu_bcast_pkg: bcast_mode_e {BCAST_WRAP, BCAST_SCALAR}, bcast_state_e {IDLE,RUN,DONE}.
//  Sub-module bcast_index_gen: (base, n, mode) -> LANES lane indices + next base; combinational.
//  Top: cache + valid bits, FSM, beat counter, output register.
// TESTING
//  1 n=12 WRAP, 16 entries written, 4 beats, ready=1 -> idx 0-7, 8-11,0-3, 4-11, 0-7; last on beat 3; done.
//  2 n=1 SCALAR, cache[0]=0x5A, 3 beats -> every lane 0x5A x3; n=3 SCALAR -> beats c0,c1,c2 replicated.
//  3 out_ready low 5 cycles mid-run -> out_data/out_valid stable; no beat lost/duplicated.
//  4 start with entries 8-15 unwritten, n=16 -> beat 1 stalls until written; FWD_EN: same-cycle issue.
//  5 num_beats=0 -> no out_valid, done 2 cycles after start; start while busy ignored.
//  6 init asserted in RUN -> out_valid=0, busy=0 next cycle, no done; new run needs rewrite.

Source files
------------

// File: rtl/npu_bcast_pkg.sv
// rtl/npu_bcast_pkg.sv - shared types for the vector broadcast unit
// Purpose: mode and FSM state enums plus the cfg_mode decode helper used by
//          vector_broadcast_unit and bcast_index_gen.
// Ports:   none (package)
package npu_bcast_pkg;

   typedef enum logic {
      BCAST_WRAP   = 1'b0,
      BCAST_SCALAR = 1'b1
   } bcast_mode_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } bcast_state_e;

   localparam logic [1:0] CFG_MODE_SCALAR = 2'd1;

   // Reserved encodings 2/3 fall back to WRAP.
   function automatic bcast_mode_e decode_mode(input logic [1:0] cfg_mode);
      return (cfg_mode == CFG_MODE_SCALAR) ? BCAST_SCALAR : BCAST_WRAP;
   endfunction

endpackage

// File: rtl/bcast_index_gen.sv
// rtl/bcast_index_gen.sv - combinational lane index and next-base generator
// Purpose: from the current base, period n and mode, produce one cache index
//          per lane and the base for the following beat.
// Ports:   base      in  ADDR_W            current base, always < n
//          n         in  ADDR_W+1          period, 1..DEPTH
//          mode      in  bcast_mode_e      WRAP or SCALAR
//          idx       out LANES x ADDR_W    cache index per lane
//          next_base out ADDR_W            base for the next beat
module bcast_index_gen
   import npu_bcast_pkg::*;
#(
   parameter int LANES  = 8,
   parameter int ADDR_W = 9
) (
   input  logic [ADDR_W-1:0]            base,
   input  logic [ADDR_W:0]              n,
   input  bcast_mode_e                  mode,
   output logic [LANES-1:0][ADDR_W-1:0] idx,
   output logic [ADDR_W-1:0]            next_base
);

   logic [ADDR_W:0] cur;
   logic [ADDR_W:0] inc;

   // Modulo is built as a chain of +1 steps that snap back to 0 on reaching n,
   // so no divider is needed; base < n keeps every step inside the period.
   always_comb begin
      cur = {1'b0, base};
      inc = '0;
      idx = '0;
      for (int j = 0; j < LANES; j++) begin
         idx[j] = cur[ADDR_W-1:0];
         if (mode == BCAST_WRAP) begin
            inc = cur + 1'b1;
            cur = (inc == n) ? '0 : inc;
         end
      end
      // After the loop, WRAP has already advanced LANES steps; SCALAR advances one.
      if (mode == BCAST_SCALAR) begin
         inc = cur + 1'b1;
         cur = (inc == n) ? '0 : inc;
      end
      next_base = cur[ADDR_W-1:0];
   end

endmodule

// File: rtl/vector_broadcast_unit.sv
// rtl/vector_broadcast_unit.sv - operand cache streaming LANES-wide beats to the PE array
// Purpose: caches up to DEPTH elements written from SRAM and emits a programmed
//          number of LANES-wide beats (WRAP or SCALAR indexing) over valid/ready,
//          pulsing done at the end of a run.
// Macro:   BCAST_FWD_EN - when defined, entries written this cycle are forwarded
//          to the issuing beat; otherwise a dependent beat waits one cycle.
// Ports:   clk, rst (sync, active-low), init (sync clear, cache data kept)
//          wr_valid/wr_addr/wr_data   LANES-element cache write, address wraps at DEPTH
//          start/cfg_mode/cfg_num_elems/cfg_num_beats   run launch and configuration
//          out_valid/out_ready/out_data/out_last        beat stream
//          busy (FSM not IDLE), done (one-cycle completion pulse)
module vector_broadcast_unit
   import npu_bcast_pkg::*;
#(
   parameter int LANES  = 8,
   parameter int DATA_W = 8,
   parameter int DEPTH  = 512,
   parameter int ADDR_W = $clog2(DEPTH),
   parameter int BEAT_W = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    init,
   input  logic                    wr_valid,
   input  logic [ADDR_W-1:0]       wr_addr,
   input  logic [LANES*DATA_W-1:0] wr_data,
   input  logic                    start,
   input  logic [1:0]              cfg_mode,
   input  logic [ADDR_W:0]         cfg_num_elems,
   input  logic [BEAT_W-1:0]       cfg_num_beats,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [LANES*DATA_W-1:0] out_data,
   output logic                    out_last,
   output logic                    busy,
   output logic                    done
);

   localparam logic [ADDR_W:0] DEPTH_N = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] ONE_N   = (ADDR_W+1)'(1);

   // Cache storage; only the valid bits are cleared by init.
   logic [DATA_W-1:0] cache_mem [DEPTH];
   logic [DEPTH-1:0]  cache_valid;

   bcast_state_e      state;
   bcast_mode_e       mode_q;
   logic [ADDR_W:0]   n_q;
   logic [BEAT_W-1:0] nbeats_q;
   logic [BEAT_W-1:0] issue_cnt_q;
   logic [ADDR_W-1:0] base_q;

   logic [LANES-1:0][ADDR_W-1:0] waddr;
   logic [ADDR_W:0]              cfg_n;
   logic                         launch;
   bcast_mode_e                  eff_mode;
   logic [ADDR_W:0]              eff_n;
   logic [ADDR_W-1:0]            eff_base;
   logic [BEAT_W-1:0]            eff_nbeats;
   logic [BEAT_W-1:0]            eff_cnt;
   logic                         want_issue;
   logic                         can_adv;
   logic                         all_valid;
   logic                         do_issue;
   logic                         accept_last;
   logic [LANES-1:0][ADDR_W-1:0] lane_idx;
   logic [ADDR_W-1:0]            next_base;
   logic [LANES-1:0]             lane_ok;
   logic [LANES-1:0][DATA_W-1:0] lane_data;

   always_comb begin
      for (int k = 0; k < LANES; k++) begin
         waddr[k] = wr_addr + ADDR_W'(k);
      end
   end

   always_comb begin
      if (cfg_num_elems == '0) begin
         cfg_n = ONE_N;
      end else if (cfg_num_elems > DEPTH_N) begin
         cfg_n = DEPTH_N;
      end else begin
         cfg_n = cfg_num_elems;
      end
   end

   // On the launch cycle the first beat is computed straight from cfg_* so that
   // out_valid can rise the cycle after start.
   assign launch     = (state == IDLE) && start && !init;
   assign eff_mode   = launch ? decode_mode(cfg_mode) : mode_q;
   assign eff_n      = launch ? cfg_n : n_q;
   assign eff_base   = launch ? '0 : base_q;
   assign eff_nbeats = launch ? cfg_num_beats : nbeats_q;
   assign eff_cnt    = launch ? '0 : issue_cnt_q;

   assign want_issue = launch ? (cfg_num_beats != '0)
                              : ((state == RUN) && (issue_cnt_q < nbeats_q));
   assign can_adv     = !out_valid || out_ready;
   assign all_valid   = &lane_ok;
   assign do_issue    = want_issue && can_adv && all_valid && !init;
   assign accept_last = out_valid && out_ready && out_last;
   assign busy        = (state != IDLE);

   bcast_index_gen #(
      .LANES  (LANES),
      .ADDR_W (ADDR_W)
   ) u_index_gen (
      .base      (eff_base),
      .n         (eff_n),
      .mode      (eff_mode),
      .idx       (lane_idx),
      .next_base (next_base)
   );

   always_comb begin
      lane_ok   = '0;
      lane_data = '0;
      for (int j = 0; j < LANES; j++) begin
         lane_ok[j]   = cache_valid[lane_idx[j]];
         lane_data[j] = cache_mem[lane_idx[j]];
`ifdef BCAST_FWD_EN
         // Later write lanes override earlier ones, matching the cache's last-write-wins.
         for (int k = 0; k < LANES; k++) begin
            if (wr_valid && !init && (waddr[k] == lane_idx[j])) begin
               lane_ok[j]   = 1'b1;
               lane_data[j] = wr_data[k*DATA_W +: DATA_W];
            end
         end
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (wr_valid && !init) begin
         for (int k = 0; k < LANES; k++) begin
            cache_mem[waddr[k]] <= wr_data[k*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst || init) begin
         cache_valid <= '0;
      end else if (wr_valid) begin
         for (int k = 0; k < LANES; k++) begin
            cache_valid[waddr[k]] <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst || init) begin
         state       <= IDLE;
         mode_q      <= BCAST_WRAP;
         n_q         <= ONE_N;
         nbeats_q    <= '0;
         issue_cnt_q <= '0;
         base_q      <= '0;
         out_valid   <= 1'b0;
         out_data    <= '0;
         out_last    <= 1'b0;
         done        <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  mode_q      <= decode_mode(cfg_mode);
                  n_q         <= cfg_n;
                  nbeats_q    <= cfg_num_beats;
                  issue_cnt_q <= '0;
                  base_q      <= '0;
                  state       <= (cfg_num_beats != '0) ? RUN : DONE;
               end
            end
            RUN: begin
               if (accept_last) begin
                  state <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b1;
            end
            default: state <= IDLE;
         endcase

         // Placed after the FSM so an issue on the launch cycle overrides the
         // base/count reset done there.
         if (do_issue) begin
            out_valid   <= 1'b1;
            out_data    <= lane_data;
            out_last    <= (eff_cnt == eff_nbeats - 1'b1);
            base_q      <= next_base;
            issue_cnt_q <= eff_cnt + 1'b1;
         end else if (can_adv) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_vector_broadcast_unit.sv
// tb/tb_vector_broadcast_unit.sv - scoreboard bench for vector_broadcast_unit
// Purpose: drives cache writes and runs, models expected beats from a mirror of
//          the cache, and compares every accepted beat plus control timing.
// Ports:   none (top-level bench); honours BCAST_FWD_EN like the design.
module tb_vector_broadcast_unit;

   localparam int LANES  = 8;
   localparam int DATA_W = 8;
   localparam int DEPTH  = 64;
   localparam int ADDR_W = 6;
   localparam int BEAT_W = 32;
   localparam int W      = LANES * DATA_W;
`ifdef BCAST_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic              init;
   logic              wr_valid;
   logic [ADDR_W-1:0] wr_addr;
   logic [W-1:0]      wr_data;
   logic              start;
   logic [1:0]        cfg_mode;
   logic [ADDR_W:0]   cfg_num_elems;
   logic [BEAT_W-1:0] cfg_num_beats;
   logic              out_valid;
   logic              out_ready;
   logic [W-1:0]      out_data;
   logic              out_last;
   logic              busy;
   logic              done;

   typedef struct {
      logic [W-1:0] data;
      logic         last;
   } beat_t;

   beat_t       exp_q[$];
   logic [7:0]  mcache [DEPTH];
   int          n_checks = 0;
   int          n_errors = 0;
   int          done_cnt = 0;

   always #5 clk = ~clk;

   vector_broadcast_unit #(
      .LANES  (LANES),
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .BEAT_W (BEAT_W)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .init          (init),
      .wr_valid      (wr_valid),
      .wr_addr       (wr_addr),
      .wr_data       (wr_data),
      .start         (start),
      .cfg_mode      (cfg_mode),
      .cfg_num_elems (cfg_num_elems),
      .cfg_num_beats (cfg_num_beats),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_data      (out_data),
      .out_last      (out_last),
      .busy          (busy),
      .done          (done)
   );

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Scoreboard: every accepted beat is popped and compared.
   always @(negedge clk) begin
      beat_t b;
      if (rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("extra_beat", 1, 0);
         end else begin
            b = exp_q.pop_front();
            check("beat_data", out_data, b.data);
            check("beat_last", W'(out_last), W'(b.last));
         end
      end
      if (rst && done) done_cnt++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [W-1:0] mirror_at(input int addr);
      logic [W-1:0] d;
      for (int k = 0; k < LANES; k++) d[k*DATA_W +: DATA_W] = mcache[(addr + k) % DEPTH];
      return d;
   endfunction

   task automatic wr_vals(input int addr, input logic [W-1:0] d);
      for (int k = 0; k < LANES; k++) mcache[(addr + k) % DEPTH] = d[k*DATA_W +: DATA_W];
      wr_addr  = addr[ADDR_W-1:0];
      wr_data  = d;
      wr_valid = 1'b1;
      step();
      wr_valid = 1'b0;
   endtask

   task automatic push_run(input int scalar, input int n, input int beats);
      int    neff;
      int    base;
      int    idx;
      beat_t b;
      neff = (n == 0) ? 1 : ((n > DEPTH) ? DEPTH : n);
      base = 0;
      for (int bn = 0; bn < beats; bn++) begin
         for (int j = 0; j < LANES; j++) begin
            idx = (scalar != 0) ? base : (base + j) % neff;
            b.data[j*DATA_W +: DATA_W] = mcache[idx];
         end
         b.last = (bn == beats - 1);
         exp_q.push_back(b);
         base = (scalar != 0) ? (base + 1) % neff : (base + LANES) % neff;
      end
   endtask

   task automatic start_run(input logic [1:0] mode, input int n, input int beats);
      cfg_mode      = mode;
      cfg_num_elems = n[ADDR_W:0];
      cfg_num_beats = beats;
      start         = 1'b1;
      step();
      start         = 1'b0;
   endtask

   task automatic wait_done(input int d0, input string tag);
      int cyc;
      cyc = 0;
      while (done_cnt == d0 && cyc < 200) begin
         step();
         cyc++;
      end
      check(tag, W'(done_cnt - d0), W'(1));
      check({tag, "_q_empty"}, W'(exp_q.size()), W'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int           d0;
      logic [W-1:0] held;

      rst = 1'b0; init = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
      start = 1'b0; cfg_mode = '0; cfg_num_elems = '0; cfg_num_beats = '0;
      out_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) mcache[i] = 8'h00;
      repeat (3) step();
      rst = 1'b1;
      step();

      // Reset state
      check("rst_valid", W'(out_valid), 0);
      check("rst_data", out_data, 0);
      check("rst_last", W'(out_last), 0);
      check("rst_busy", W'(busy), 0);
      check("rst_done", W'(done), 0);

      // 1: WRAP n=12 over 16 written entries
      wr_vals(0, 64'h17161514_13121110);
      wr_vals(8, 64'h1f1e1d1c_1b1a1918);
      push_run(0, 12, 4);
      d0 = done_cnt;
      start_run(2'd0, 12, 4);
      check("t1_latency", W'(out_valid), 1);
      check("t1_busy", W'(busy), 1);
      wait_done(d0, "t1_done");

      // 2: SCALAR replication, n=1 then n=3; n=0 treated as 1
      wr_vals(0, 64'hc7c6c5c4_c3c2c15a);
      push_run(1, 1, 3);
      d0 = done_cnt;
      start_run(2'd1, 1, 3);
      wait_done(d0, "t2a_done");
      push_run(1, 3, 3);
      d0 = done_cnt;
      start_run(2'd1, 3, 3);
      wait_done(d0, "t2b_done");
      push_run(0, 0, 1);
      d0 = done_cnt;
      start_run(2'd3, 0, 1);
      wait_done(d0, "t2c_done");

      // 3: backpressure holds the beat stable
      push_run(0, 16, 10);
      d0 = done_cnt;
      start_run(2'd0, 16, 10);
      step();
      step();
      out_ready = 1'b0;
      held = out_data;
      for (int i = 0; i < 5; i++) begin
         step();
         check("t3_hold_valid", W'(out_valid), 1);
         check("t3_hold_data", out_data, held);
      end
      out_ready = 1'b1;
      wait_done(d0, "t3_done");

      // 5a: zero beats -> done two cycles after start, no beat
      d0 = done_cnt;
      start_run(2'd0, 8, 0);
      check("t5_valid_t1", W'(out_valid), 0);
      check("t5_busy_t1", W'(busy), 1);
      check("t5_done_t1", W'(done), 0);
      step();
      check("t5_done_t2", W'(done), 1);
      check("t5_busy_t2", W'(busy), 0);
      check("t5_valid_t2", W'(out_valid), 0);
      step();
      check("t5_done_cnt", W'(done_cnt - d0), 1);

      // 5b: start while busy is ignored
      push_run(0, 8, 4);
      d0 = done_cnt;
      start_run(2'd0, 8, 4);
      start_run(2'd1, 3, 3);
      wait_done(d0, "t5b_done");
      repeat (5) step();
      check("t5b_single_done", W'(done_cnt - d0), 1);

      // 7: n above DEPTH clamps to DEPTH; a write wraps at DEPTH
      for (int i = 0; i < 8; i++) wr_vals(4 + 8 * i, {$urandom, $urandom});
      push_run(0, 100, 9);
      d0 = done_cnt;
      start_run(2'd0, 100, 9);
      wait_done(d0, "t7_done");

      // 4: beat 1 waits for entries 8-15
      init = 1'b1;
      step();
      init = 1'b0;
      wr_vals(0, mirror_at(0));
      push_run(0, 16, 2);
      d0 = done_cnt;
      start_run(2'd0, 16, 2);
      check("t4_beat0", W'(out_valid), 1);
      step();
      check("t4_stall_a", W'(out_valid), 0);
      step();
      step();
      check("t4_stall_b", W'(out_valid), 0);
      wr_vals(8, mirror_at(8));
      check("t4_after_w1", W'(out_valid), W'(FWD));
      step();
      check("t4_after_w2", W'(out_valid), W'(!FWD));
      wait_done(d0, "t4_done");

      // 6: init mid-run aborts without done; next run needs a rewrite
      push_run(0, 16, 20);
      d0 = done_cnt;
      start_run(2'd0, 16, 20);
      step();
      step();
      init = 1'b1;
      out_ready = 1'b0;
      step();
      init = 1'b0;
      out_ready = 1'b1;
      check("t6_valid", W'(out_valid), 0);
      check("t6_busy", W'(busy), 0);
      exp_q.delete();
      repeat (5) step();
      check("t6_no_done", W'(done_cnt - d0), 0);
      push_run(0, 8, 1);
      d0 = done_cnt;
      start_run(2'd0, 8, 1);
      step();
      step();
      check("t6_needs_rewrite", W'(out_valid), 0);
      wr_vals(0, mirror_at(0));
      wait_done(d0, "t6_done");

      repeat (3) step();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
